// File: rtl/eq_ctrl_pkg.sv
// Shared types and defaults for the equalizer frame controller.
package eq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BYPASS,
    ST_WAIT_SOF,
    ST_TRAIN,
    ST_DATA
  } state_e;

  localparam logic [7:0]  SR_TRAIN_LEN_DEF = 8'd130;
  localparam logic [7:0]  SR_ENABLE_DEF    = 8'd131;
  localparam logic [15:0] TRAIN_LEN_DEF    = 16'd64;

endpackage

// File: rtl/eq_frame_ctrl_stats.sv
// Frame and short-frame event counters; both wrap at all-ones.
module eq_frame_ctrl_stats (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        frame_done_i,
  input  logic        short_i,
  output logic [31:0] frame_cnt_o,
  output logic [15:0] short_cnt_o
);

  logic [31:0] frame_cnt_q;
  logic [15:0] short_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_cnt_q <= '0;
      short_cnt_q <= '0;
    end else begin
      if (frame_done_i) frame_cnt_q <= frame_cnt_q + 32'd1;
      if (short_i)      short_cnt_q <= short_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign short_cnt_o = short_cnt_q;

endmodule

// File: rtl/eq_frame_ctrl.sv
// Marks start-of-frame and training beats on a pass-through sample stream.
// Optional statistics outputs under EQ_FRAME_CTRL_STATS_EN.
module eq_frame_ctrl
  import eq_ctrl_pkg::*;
#(
  parameter logic [7:0]  SR_TRAIN_LEN      = SR_TRAIN_LEN_DEF,
  parameter logic [7:0]  SR_ENABLE         = SR_ENABLE_DEF,
  parameter logic [15:0] TRAIN_LEN_DEFAULT = TRAIN_LEN_DEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [31:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  input  logic        i_eob,
  output logic        i_tready,
  output logic [31:0] o_tdata,
  output logic        o_tlast,
  output logic        o_tvalid,
  input  logic        o_tready,
  output logic        sof_o,
  output logic        train_o,
  output logic        short_frame_o
`ifdef EQ_FRAME_CTRL_STATS_EN
  ,
  output logic [31:0] frame_cnt,
  output logic [15:0] short_cnt
`endif
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q;
  logic        en_q;
  logic        short_q, short_d;
  logic        beat, fend;
  logic        unused_set_data;

  assign o_tdata  = i_tdata;
  assign o_tlast  = i_tlast;
  assign o_tvalid = i_tvalid;
  assign i_tready = o_tready;

  assign beat = i_tvalid && o_tready;
  assign fend = beat && i_tlast && i_eob;
  assign unused_set_data = ^set_data[31:16];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_BYPASS;
      cnt_q   <= '0;
      len_q   <= TRAIN_LEN_DEFAULT;
      en_q    <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      if (set_stb && set_addr == SR_TRAIN_LEN) len_q <= set_data[15:0];
      if (set_stb && set_addr == SR_ENABLE)    en_q  <= set_data[0];
    end
  end

  // en_q is sampled only at frame end in TRAIN/DATA, which defers enable writes.
  // cnt_q holds the training beats still due, including the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    short_d = 1'b0;
    unique case (state_q)
      ST_BYPASS: if (en_q) state_d = ST_WAIT_SOF;
      ST_WAIT_SOF: begin
        if (!en_q) begin
          state_d = ST_BYPASS;
        end else if (beat) begin
          cnt_d = (len_q != '0) ? len_q - 16'd1 : '0;
          if (fend) begin
            short_d = (len_q > 16'd1);
          end else begin
            // a one-beat training period is complete on the SOF beat itself
            state_d = (len_q > 16'd1) ? ST_TRAIN : ST_DATA;
          end
        end
      end
      ST_TRAIN: begin
        if (beat) begin
          cnt_d = cnt_q - 16'd1;
          if (fend) begin
            short_d = (cnt_q != 16'd1);
            state_d = en_q ? ST_WAIT_SOF : ST_BYPASS;
          end else if (cnt_q == 16'd1) begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: if (fend) state_d = en_q ? ST_WAIT_SOF : ST_BYPASS;
      default: state_d = ST_BYPASS;
    endcase
  end

  always_comb begin
    sof_o   = 1'b0;
    train_o = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ST_WAIT_SOF: begin
          sof_o   = en_q;
          train_o = en_q && (len_q != '0);
        end
        ST_TRAIN: train_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign short_frame_o = short_q;

`ifdef EQ_FRAME_CTRL_STATS_EN
  logic frame_done;
  assign frame_done = fend && ((state_q == ST_TRAIN) || (state_q == ST_DATA) ||
                               (state_q == ST_WAIT_SOF && en_q));

  eq_frame_ctrl_stats u_stats (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .frame_done_i (frame_done),
    .short_i      (short_q),
    .frame_cnt_o  (frame_cnt),
    .short_cnt_o  (short_cnt)
  );
`endif

endmodule

// File: tb/tb_eq_frame_ctrl.sv
// Scoreboard bench for eq_frame_ctrl: frame-level reference model feeds
// expected beats and short pulses to a decoupled negedge monitor.
module tb_eq_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic [31:0] i_tdata = '0;
  logic        i_tlast = 1'b0;
  logic        i_tvalid = 1'b0;
  logic        i_eob = 1'b0;
  logic        i_tready;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready = 1'b1;
  logic        sof_o;
  logic        train_o;
  logic        short_frame_o;
`ifdef EQ_FRAME_CTRL_STATS_EN
  logic [31:0] frame_cnt;
  logic [15:0] short_cnt;
`endif

  eq_frame_ctrl #(
    .SR_TRAIN_LEN      (8'd130),
    .SR_ENABLE         (8'd131),
    .TRAIN_LEN_DEFAULT (16'd64)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .set_stb       (set_stb),
    .set_addr      (set_addr),
    .set_data      (set_data),
    .i_tdata       (i_tdata),
    .i_tlast       (i_tlast),
    .i_tvalid      (i_tvalid),
    .i_eob         (i_eob),
    .i_tready      (i_tready),
    .o_tdata       (o_tdata),
    .o_tlast       (o_tlast),
    .o_tvalid      (o_tvalid),
    .o_tready      (o_tready),
    .sof_o         (sof_o),
    .train_o       (train_o),
    .short_frame_o (short_frame_o)
`ifdef EQ_FRAME_CTRL_STATS_EN
    ,
    .frame_cnt     (frame_cnt),
    .short_cnt     (short_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        last;
    logic        sof;
    logic        train;
  } exp_t;

  exp_t expq[$];
  int   shq[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  // Reference model: frame-level view (is a frame open, which beat of it, its latched length).
  int          m_shadow = 64;
  logic        m_en = 1'b0;
  logic        m_active = 1'b0;
  logic        m_in_frame = 1'b0;
  int          m_idx = 0;
  int          m_len = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic model_beat(input logic [31:0] d, input logic last, input logic eob);
    exp_t e;
    logic sof;
    logic trn;
    sof = 1'b0;
    if (!m_in_frame) begin
      m_active = m_en;
      if (m_active) begin
        m_in_frame = 1'b1;
        m_idx      = 0;
        m_len      = m_shadow;
        sof        = 1'b1;
      end
    end
    trn = m_in_frame && (m_idx < m_len);
    e.d = d; e.last = last; e.sof = sof; e.train = trn;
    expq.push_back(e);
    if (m_in_frame && last && eob) begin
      if (trn && m_idx != m_len - 1) shq.push_back(cyc + 1);
      m_in_frame = 1'b0;
    end
    m_idx++;
  endtask

  task automatic drive(input logic v, input logic rdy, input logic [31:0] d, input logic last,
                       input logic eob, input logic stb, input logic [7:0] a, input logic [31:0] sd);
    i_tvalid = v; o_tready = rdy; i_tdata = d; i_tlast = last; i_eob = eob;
    set_stb = stb; set_addr = a; set_data = sd;
    if (v && rdy) model_beat(d, last, eob);
    if (stb && a == 8'd130) m_shadow = int'(sd[15:0]);
    if (stb && a == 8'd131) m_en = sd[0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] sd);
    drive(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, a, sd);
  endtask

  task automatic beat(input logic last, input logic eob, input int stall_pct);
    logic [31:0] d;
    logic        rdy;
    int          tries;
    d = $urandom;
    tries = 0;
    do begin
      rdy = (tries >= 16) || ($urandom_range(99) >= stall_pct);
      drive(1'b1, rdy, d, last, eob, 1'b0, 8'd0, 32'd0);
      tries++;
    end while (!rdy);
  endtask

  task automatic packet(input int n, input logic eob, input int stall_pct);
    for (int i = 0; i < n; i++) begin
      if (stall_pct > 0 && $urandom_range(99) < stall_pct) idle(1);
      beat(i == n - 1, eob, stall_pct);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    i_tvalid = 1'b0; set_stb = 1'b0; o_tready = 1'b1;
    m_en = 1'b0; m_shadow = 64; m_in_frame = 1'b0; m_active = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_sof", sof_o, 1'b0);
    chk("rst_train", train_o, 1'b0);
    chk("rst_short", short_frame_o, 1'b0);
    chk("rst_ready", i_tready, 1'b1);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every transferred output beat.
  exp_t mon_e;
  always @(negedge clk) begin
    if (o_tvalid && o_tready) begin
      if (expq.size() == 0) begin
        fail_now("unexpected_beat");
      end else begin
        mon_e = expq.pop_front();
        chk("data", o_tdata, mon_e.d);
        chk("flags{last,sof,train,ready}", {o_tlast, sof_o, train_o, i_tready},
            {mon_e.last, mon_e.sof, mon_e.train, 1'b1});
      end
    end
    if (short_frame_o) begin
      if (shq.size() == 0) fail_now("short_spurious");
      else chk("short_cycle", cyc, shq.pop_front());
    end
    if (shq.size() > 0 && shq[0] < cyc) begin
      chk("short_missed", 0, shq.pop_front());
    end
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Disabled after reset: bypass, then default training length.
    packet(5, 1'b1, 0);
    wr(8'd131, 32'd1); idle(3);
    packet(66, 1'b1, 0);

    // Length 4, 10-beat packet; length 8, short 5-beat packet, then a normal one.
    wr(8'd130, 32'd4); idle(2);
    packet(10, 1'b1, 0);
    wr(8'd130, 32'd8); idle(2);
    packet(5, 1'b1, 0);
    packet(10, 1'b1, 0);

    // Length 0 and 1, and single-beat frames.
    wr(8'd130, 32'd0); idle(2);
    packet(6, 1'b1, 0);
    wr(8'd130, 32'd1); idle(2);
    packet(3, 1'b1, 0);
    packet(1, 1'b1, 0);
    wr(8'd130, 32'd4); idle(2);
    packet(1, 1'b1, 0);

    // Stalls with length 4.
    for (int k = 0; k < 4; k++) packet(12, 1'b1, 35);

    // Length and enable changed mid-DATA; ignored address carries a 1.
    for (int i = 0; i < 10; i++) begin
      beat(i == 9, 1'b1, 0);
      if (i == 5) begin
        wr(8'd130, 32'd6);
        wr(8'd131, 32'd0);
        wr(8'd132, 32'd1);
      end
    end
    packet(8, 1'b1, 0);
    wr(8'd131, 32'd1); idle(3);
    packet(10, 1'b1, 0);

    // tlast without eob does not close the frame.
    packet(5, 1'b0, 0);
    packet(5, 1'b1, 0);

    // Random traffic and settings.
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(3) == 0) wr(8'd130, 32'($urandom_range(9)));
      if ($urandom_range(7) == 0) begin
        wr(8'd131, 32'($urandom_range(1)));
        idle(3);
      end
      packet($urandom_range(12, 1), $urandom_range(3) != 0, 25);
    end

    // Reset mid-frame: no short pulse, back to bypass.
    wr(8'd131, 32'd1); wr(8'd130, 32'd8); idle(3);
    packet(3, 1'b0, 0);
    do_reset();
    packet(6, 1'b1, 0);

    idle(4);
    chk("scoreboard_drained", expq.size(), 0);
    chk("short_drained", shq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
